mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-master, one-slave arbiter that shares the core's single memory bus port between instruction fetch (ifu, master 0) and the execute unit's load/store path (exu, master 1). It sits between the ifu/exu valid-ready memory interfaces and the bus slave. It holds a granted request stable until the slave accepts it, with exu priority bounded by an anti-starvation counter. A small in-order ID FIFO routes each response back to the master that issued the matching request.

## Interface
- OUTSTANDING, default 2: maximum slave requests in flight awaiting response; power of 2, ≥1.
- STARVE_LIMIT, default 4: consecutive exu wins over a waiting ifu before ifu is forced a grant; ≥1.
- clk  input  1  core clock
- rst_n  input  1  reset; one clock, reset asynchronous and active-low
- m0_req_valid_i / m1_req_valid_i  input  1  master request valid (m0 = ifu, m1 = exu)
- m0_req_ready_o / m1_req_ready_o  output  1  request accepted this cycle
- m0_addr_i / m1_addr_i  input  32  byte address
- m0_wdata_i / m1_wdata_i  input  32  write data
- m0_we_i / m1_we_i  input  1  write enable
- m0_sel_i / m1_sel_i  input  4  byte lanes
- m0_rsp_valid_o / m1_rsp_valid_o  output  1  response valid to master
- m0_rsp_ready_i / m1_rsp_ready_i  input  1  master accepts response
- m0_rdata_o / m1_rdata_o  output  32  response data (slave rdata broadcast to both)
- s_req_valid_o, s_req_ready_i, s_addr_o[32], s_wdata_o[32], s_we_o, s_sel_o[4]: slave request channel
- s_rsp_valid_i, s_rsp_ready_o, s_rdata_i[32]: slave response channel

## Operation
- Every slave request produces exactly one slave response, reads and writes alike, in request order.
- Selection when unlocked: only one master valid → that master. Both valid → exu, unless starve_cnt == STARVE_LIMIT, then ifu.
- The selected master's addr/wdata/we/sel/valid drive the slave. s_req_valid_o = sel_valid & ~fifo_full. Selected mN_req_ready_o = s_req_ready_i & ~fifo_full. The unselected ready is 0.
- Lock: if the selected master is valid and no handshake occurs, lock ← 1 and lock_id ← selected. While locked, selection = lock_id regardless of priority. Lock clears on that master's handshake.
- starve_cnt: increments (saturating at STARVE_LIMIT) on an exu handshake while m0_req_valid_i = 1. Clears on any ifu handshake. Holds otherwise.
- ID FIFO, depth OUTSTANDING: pushes the granted id on s_req handshake. Pops on s_rsp handshake.
- Response routing: head id selects the master. mN_rsp_valid_o = s_rsp_valid_i & ~empty & (head == N). s_rsp_ready_o = head master's rsp_ready & ~empty.
- FIFO full blocks new grants even when a pop happens in the same cycle. Push and pop in the same cycle when not full are both performed; count is unchanged.
- s_rsp_valid_i while the FIFO is empty is a protocol error: it is ignored, s_rsp_ready_o = 0, and no master sees it.

## Timing
- Request and response paths are zero-latency combinational pass-through; the arbiter adds no cycles.
- Registered state: lock, lock_id, starve_cnt, FIFO pointers/count. All reset to 0 / empty asynchronously.
- Outputs during and just after reset: all req_ready and rsp_valid outputs = 0 only as far as inputs allow. Specifically, rsp_valid = 0 (FIFO empty). s_req_valid_o follows the masters' valids (unlocked, exu priority).
- Reset mid-transaction discards outstanding IDs. Responses arriving after reset are dropped per the empty-FIFO rule.
- Back-to-back grants are allowed every cycle up to OUTSTANDING in flight.

## Structure
- Shared package mem_arb_pkg: typedef enum logic {MST_IFU = 1'b0, MST_EXU = 1'b1} mst_id_e; the master count constant.
- One sub-module, arb_id_fifo: a synchronous FIFO parameterised by depth and data width, with full/empty flags and an asynchronous active-low reset. The arbiter top holds the selection, lock and starve logic.

## Test plan
- Single ifu read to addr 0x100, slave ready, response 0xDEADBEEF two cycles later → m0_rsp_valid_o pulses with m0_rdata_o = 0xDEADBEEF; m1 sees no rsp_valid.
- Both masters valid continuously, slave always ready, STARVE_LIMIT = 4 → grant sequence exu, exu, exu, exu, ifu, exu…; starve_cnt returns to 0 after the ifu grant.
- ifu selected and slave stalls 3 cycles while exu raises valid → s_addr_o stays at the ifu address until the handshake; exu is granted next.
- OUTSTANDING = 2, two requests accepted, no responses → third request sees req_ready = 0. A response with pop in the same cycle still blocks the grant; the grant happens the following cycle.
- Interleaved exu write then ifu read, responses back in order → first response routed to m1, second to m0. The m1 rsp_ready held low 2 cycles stalls s_rsp_ready_o.
- rst_n asserted with 2 requests outstanding, then a stray s_rsp_valid_i = 1 → s_rsp_ready_o = 0 and no master rsp_valid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the core memory-port arbiter: master ids and the
// request payload that is steered from the selected master to the slave.
package mem_arb_pkg;

  typedef enum logic {
    MST_IFU = 1'b0,
    MST_EXU = 1'b1
  } mst_id_e;

  localparam int unsigned NUM_MST = 2;
  localparam int unsigned ID_W    = 1;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SEL_W   = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [SEL_W-1:0]  sel;
  } mem_req_t;

endpackage

// File: rtl/arb_id_fifo.sv
// Small synchronous FIFO with full/empty flags; holds the issuing master id
// of each request in flight so responses can be routed back in order.
module arb_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between ifu (master 0) and exu (master 1):
// exu-priority selection with grant lock and ifu anti-starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned OUTSTANDING  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_req_valid_i,
  output logic              m0_req_ready_o,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic              m0_we_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  output logic              m0_rsp_valid_o,
  input  logic              m0_rsp_ready_i,
  output logic [DATA_W-1:0] m0_rdata_o,

  input  logic              m1_req_valid_i,
  output logic              m1_req_ready_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic              m1_we_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  output logic              m1_rsp_valid_o,
  input  logic              m1_rsp_ready_i,
  output logic [DATA_W-1:0] m1_rdata_o,

  output logic              s_req_valid_o,
  input  logic              s_req_ready_i,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  output logic              s_we_o,
  output logic [SEL_W-1:0]  s_sel_o,

  input  logic              s_rsp_valid_i,
  output logic              s_rsp_ready_o,
  input  logic [DATA_W-1:0] s_rdata_i
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  mem_req_t          m0_req;
  mem_req_t          m1_req;
  mem_req_t          sel_req;
  mst_id_e           sel_id;
  logic              sel_valid;
  logic              req_hs;
  logic              rsp_hs;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ID_W-1:0]   head_raw;
  mst_id_e           head_id;

  logic              lock_q;
  logic              lock_d;
  mst_id_e           lock_id_q;
  mst_id_e           lock_id_d;
  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;

  assign m0_req = '{addr: m0_addr_i, wdata: m0_wdata_i, we: m0_we_i, sel: m0_sel_i};
  assign m1_req = '{addr: m1_addr_i, wdata: m1_wdata_i, we: m1_we_i, sel: m1_sel_i};

  // Selection: lock wins, then exu unless ifu has been passed over too often.
  always_comb begin
    sel_id = MST_EXU;
    if (lock_q) begin
      sel_id = lock_id_q;
    end else if (m0_req_valid_i && m1_req_valid_i) begin
      sel_id = (starve_q == STARVE_W'(STARVE_LIMIT)) ? MST_IFU : MST_EXU;
    end else if (m0_req_valid_i) begin
      sel_id = MST_IFU;
    end
  end

  assign sel_valid = (sel_id == MST_IFU) ? m0_req_valid_i : m1_req_valid_i;
  assign sel_req   = (sel_id == MST_IFU) ? m0_req : m1_req;

  assign s_req_valid_o  = sel_valid & ~fifo_full;
  assign s_addr_o       = sel_req.addr;
  assign s_wdata_o      = sel_req.wdata;
  assign s_we_o         = sel_req.we;
  assign s_sel_o        = sel_req.sel;
  assign m0_req_ready_o = (sel_id == MST_IFU) & s_req_ready_i & ~fifo_full;
  assign m1_req_ready_o = (sel_id == MST_EXU) & s_req_ready_i & ~fifo_full;
  assign req_hs         = s_req_valid_o & s_req_ready_i;

  // Next-state for grant lock and starvation counter.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    starve_d  = starve_q;
    if (req_hs) begin
      lock_d = 1'b0;
    end else if (sel_valid) begin
      lock_d    = 1'b1;
      lock_id_d = sel_id;
    end
    if (req_hs && sel_id == MST_IFU) begin
      starve_d = '0;
    end else if (req_hs && m0_req_valid_i &&
                 starve_q != STARVE_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= MST_IFU;
      starve_q  <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      starve_q  <= starve_d;
    end
  end

  arb_id_fifo #(
    .DEPTH (OUTSTANDING),
    .DW    (ID_W)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_hs),
    .din   (ID_W'(sel_id)),
    .pop   (rsp_hs),
    .dout  (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Response routing by the oldest outstanding id; stray responses are ignored.
  assign head_id        = mst_id_e'(head_raw);
  assign m0_rsp_valid_o = s_rsp_valid_i & ~fifo_empty & (head_id == MST_IFU);
  assign m1_rsp_valid_o = s_rsp_valid_i & ~fifo_empty & (head_id == MST_EXU);
  assign s_rsp_ready_o  = ~fifo_empty &
                          ((head_id == MST_IFU) ? m0_rsp_ready_i : m1_rsp_ready_i);
  assign rsp_hs         = s_rsp_valid_i & s_rsp_ready_o;
  assign m0_rdata_o     = s_rdata_i;
  assign m1_rdata_o     = s_rdata_i;

endmodule
